// File: rtl/uart_rx_core_fifo.sv
// UART receiver with run-time frame format (5..9 data bits, none/odd/even
// parity, 0/1/2 stop bits), per-character error flags and a FWFT RX FIFO.
module uart_rx_core_fifo #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [DIV_WIDTH-1:0]          cfg_div,
   input  logic [3:0]                    cfg_width,
   input  logic [1:0]                    cfg_parity,
   input  logic [1:0]                    cfg_stop,
   input  logic                          uart_rx,
   output logic [8:0]                    m_tdata,
   output logic [2:0]                    m_tuser,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   output logic                          rx_busy
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = AW + 1;
   localparam int unsigned PW   = $clog2(OVERSAMPLE);
   localparam int unsigned HALF = OVERSAMPLE / 2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef struct packed {
      logic       brk;
      logic       perr;
      logic       ferr;
      logic [8:0] data;
   } rx_char_t;

   // Synchroniser, tick divider and oversample phase
   logic                 rx_meta_q, rx_sync_q;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [PW-1:0]        ph_q, ph_d;
   logic                 tick_c, sample_c, restart_c, last_c;

   // Frame FSM and latched frame format
   logic [2:0] state_q, state_d;
   logic [3:0] bit_q, bit_d;
   logic [1:0] stop_cnt_q, stop_cnt_d;
   logic [3:0] width_q, width_d;
   logic [1:0] par_q, par_d;
   logic [1:0] stop_q, stop_d;
   logic [8:0] data_q, data_d;
   logic       perr_q, perr_d;
   logic       ferr_q, ferr_d;
   logic       brk_q, brk_d;
   logic       parzero_q, parzero_d;
   logic       push_q, push_d;
   rx_char_t   wr_q, wr_d;
   logic       busy_q, busy_d;

   // FIFO
   rx_char_t          mem [FIFO_DEPTH];
   rx_char_t          head_c;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              valid_q, valid_d;
   logic              overrun_q, overrun_d;
   logic              full_c, pop_c, push_ok_c;

   assign tick_c   = (div_q == '0);
   assign sample_c = tick_c && (ph_q == PW'(HALF - 1));

   // Next-state logic: tick divider, phase counter and receive FSM
   always_comb begin
      state_d    = state_q;
      bit_d      = bit_q;
      stop_cnt_d = stop_cnt_q;
      width_d    = width_q;
      par_d      = par_q;
      stop_d     = stop_q;
      data_d     = data_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      brk_d      = brk_q;
      parzero_d  = parzero_q;
      push_d     = 1'b0;
      wr_d       = wr_q;
      restart_c  = 1'b0;
      last_c     = 1'b0;

      if (state_q == ST_IDLE) begin
         ph_d = '0;
      end else if (tick_c) begin
         ph_d = (ph_q == PW'(OVERSAMPLE - 1)) ? '0 : ph_q + PW'(1);
      end else begin
         ph_d = ph_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (!rx_sync_q) begin
               state_d    = ST_START;
               restart_c  = 1'b1;
               width_d    = (cfg_width >= 4'd5 && cfg_width <= 4'd9) ? cfg_width : 4'd8;
               par_d      = (cfg_parity == 2'd3) ? 2'd0 : cfg_parity;
               stop_d     = (cfg_stop == 2'd3) ? 2'd1 : cfg_stop;
               bit_d      = '0;
               stop_cnt_d = '0;
               data_d     = '0;
               perr_d     = 1'b0;
               ferr_d     = 1'b0;
               brk_d      = 1'b0;
               parzero_d  = 1'b1;
            end
         end
         ST_START: begin
            if (sample_c) begin
               state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (sample_c) begin
               data_d[bit_q] = rx_sync_q;
               if (bit_q == width_q - 4'd1) begin
                  if (par_q != 2'd0)      state_d = ST_PARITY;
                  else if (stop_q != 2'd0) state_d = ST_STOP;
                  else                     last_c  = 1'b1;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (sample_c) begin
               perr_d    = ((^data_q) ^ rx_sync_q) != (par_q == 2'd1);
               parzero_d = !rx_sync_q;
               if (stop_q != 2'd0) state_d = ST_STOP;
               else                last_c  = 1'b1;
            end
         end
         ST_STOP: begin
            if (sample_c) begin
               if (!rx_sync_q) ferr_d = 1'b1;
               if (stop_cnt_q == 2'd0) begin
                  brk_d = (data_q == '0) && parzero_q && !rx_sync_q;
               end
               if (stop_cnt_q == stop_q - 2'd1) last_c = 1'b1;
               else                             stop_cnt_d = stop_cnt_q + 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Leave for IDLE straight after the final sample so a new start can be seen early
      if (last_c) begin
         state_d = ST_IDLE;
         push_d  = 1'b1;
         wr_d    = '{brk: brk_d, perr: perr_d, ferr: ferr_d, data: data_d};
      end

      div_d  = (restart_c || tick_c) ? cfg_div : div_q - DIV_WIDTH'(1);
      busy_d = (state_d != ST_IDLE);
   end

   // FIFO bookkeeping: push from the FSM, pop on handshake, drop when full
   always_comb begin
      full_c    = (count_q == CW'(FIFO_DEPTH));
      pop_c     = valid_q && m_tready;
      push_ok_c = push_q && (!full_c || pop_c);
      wr_ptr_d  = push_ok_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d   = count_q;
      if (push_ok_c && !pop_c)      count_d = count_q + CW'(1);
      else if (!push_ok_c && pop_c) count_d = count_q - CW'(1);
      valid_d   = (count_d != '0);
      overrun_d = push_q && full_c && !pop_c;
   end

   // State registers with synchronous reset
   always_ff @(posedge aclk) begin
      if (areset) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         div_q      <= '0;
         ph_q       <= '0;
         state_q    <= ST_IDLE;
         bit_q      <= '0;
         stop_cnt_q <= '0;
         width_q    <= 4'd8;
         par_q      <= '0;
         stop_q     <= 2'd1;
         data_q     <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
         parzero_q  <= 1'b1;
         push_q     <= 1'b0;
         wr_q       <= '0;
         busy_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         rx_meta_q  <= uart_rx;
         rx_sync_q  <= rx_meta_q;
         div_q      <= div_d;
         ph_q       <= ph_d;
         state_q    <= state_d;
         bit_q      <= bit_d;
         stop_cnt_q <= stop_cnt_d;
         width_q    <= width_d;
         par_q      <= par_d;
         stop_q     <= stop_d;
         data_q     <= data_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         brk_q      <= brk_d;
         parzero_q  <= parzero_d;
         push_q     <= push_d;
         wr_q       <= wr_d;
         busy_q     <= busy_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge aclk) begin
      if (push_ok_c) mem[wr_ptr_q] <= wr_q;
   end

   assign head_c     = valid_q ? mem[rd_ptr_q] : '0;
   assign m_tdata    = head_c.data;
   assign m_tuser    = {head_c.brk, head_c.perr, head_c.ferr};
   assign m_tvalid   = valid_q;
   assign fifo_count = count_q;
   assign overrun    = overrun_q;
   assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_core_fifo.sv
// Directed bench for uart_rx_core_fifo: frame formats, error flags, FIFO, reset.
module tb_uart_rx_core_fifo;

   logic        aclk = 1'b0;
   logic        areset;
   logic [15:0] cfg_div;
   logic [3:0]  cfg_width;
   logic [1:0]  cfg_parity;
   logic [1:0]  cfg_stop;
   logic        uart_rx;
   logic [8:0]  m_tdata;
   logic [2:0]  m_tuser;
   logic        m_tvalid;
   logic        m_tready;
   logic [2:0]  fifo_count;
   logic        overrun;
   logic        rx_busy;

   int checks   = 0;
   int failures = 0;
   int bit_cyc  = 432;
   int ovr_cnt  = 0;
   int ovr_base;

   uart_rx_core_fifo #(.FIFO_DEPTH(4), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
      .aclk(aclk), .areset(areset), .cfg_div(cfg_div), .cfg_width(cfg_width),
      .cfg_parity(cfg_parity), .cfg_stop(cfg_stop), .uart_rx(uart_rx),
      .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .fifo_count(fifo_count), .overrun(overrun), .rx_busy(rx_busy)
   );

   always #10 aclk = ~aclk;

   always @(negedge aclk) if (overrun) ovr_cnt++;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge aclk);
   endtask

   task automatic send_bit(input logic b);
      uart_rx = b;
      wait_cyc(bit_cyc);
   endtask

   task automatic set_cfg(input int w, input int par, input int stp);
      cfg_width  = 4'(w);
      cfg_parity = 2'(par);
      cfg_stop   = 2'(stp);
   endtask

   // par: 0 none, 1 odd, 2 even; flip corrupts the parity bit
   task automatic send_frame(input logic [8:0] d, input int w, input int par,
                             input logic flip, input int nstop, input logic stop_lvl);
      logic p;
      send_bit(1'b0);
      p = 1'b0;
      for (int i = 0; i < w; i++) begin
         send_bit(d[i]);
         p = p ^ d[i];
      end
      if (par != 0) send_bit(((par == 1) ? ~p : p) ^ flip);
      for (int i = 0; i < nstop; i++) send_bit(stop_lvl);
      uart_rx = 1'b1;
   endtask

   task automatic pop_chk(input string tag, input logic [8:0] d, input logic [2:0] u);
      chk({tag, "_valid"}, m_tvalid, 1);
      chk({tag, "_data"}, m_tdata, d);
      chk({tag, "_user"}, m_tuser, u);
      m_tready = 1'b1;
      wait_cyc(1);
      m_tready = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tvalid"}, m_tvalid, 0);
      chk({tag, "_tdata"}, m_tdata, 0);
      chk({tag, "_tuser"}, m_tuser, 0);
      chk({tag, "_count"}, fifo_count, 0);
      chk({tag, "_overrun"}, overrun, 0);
      chk({tag, "_busy"}, rx_busy, 0);
   endtask

   initial begin
      areset   = 1'b1;
      uart_rx  = 1'b1;
      m_tready = 1'b0;
      cfg_div  = 16'd26;
      set_cfg(8, 0, 1);
      wait_cyc(5);
      chk_all_zero("reset");
      areset = 1'b0;
      wait_cyc(20);

      // 1: 8N1 0x48, then pop empties the FIFO
      send_frame(9'h048, 8, 0, 1'b0, 1, 1'b1);
      wait_cyc(4);
      chk("t1_count", fifo_count, 1);
      chk("t1_data", m_tdata, 9'h048);
      chk("t1_user", m_tuser, 3'b000);
      wait_cyc(10);
      chk("t1_hold", m_tdata, 9'h048);
      pop_chk("t1", 9'h048, 3'b000);
      chk("t1_empty", m_tvalid, 0);
      chk("t1_count0", fifo_count, 0);

      // 2: 8E2 0x6F with a corrupted parity bit
      set_cfg(8, 2, 2);
      send_frame(9'h06F, 8, 2, 1'b1, 2, 1'b1);
      wait_cyc(4);
      pop_chk("t2", 9'h06F, 3'b010);

      // Faster baud from here on; takes effect at the next start detection
      cfg_div = 16'd4;
      bit_cyc = 80;
      wait_cyc(10);

      // 3: 7O1 0x55 with low stop bit, next frame back to back
      set_cfg(7, 1, 1);
      send_frame(9'h055, 7, 1, 1'b0, 1, 1'b0);
      send_frame(9'h02A, 7, 1, 1'b0, 1, 1'b1);
      wait_cyc(4);
      chk("t3_count", fifo_count, 2);
      pop_chk("t3a", 9'h055, 3'b001);
      pop_chk("t3b", 9'h02A, 3'b000);

      // 4: 8N1 break, line low for 12 bit-times
      set_cfg(8, 0, 1);
      uart_rx = 1'b0;
      wait_cyc(12 * bit_cyc);
      uart_rx = 1'b1;
      wait_cyc(10 * bit_cyc);
      pop_chk("t4", 9'h000, 3'b101);
      m_tready = 1'b1;
      wait_cyc(6);
      m_tready = 1'b0;
      chk("t4_flushed", fifo_count, 0);

      // 9-bit data, and 5-bit data with no stop bit
      set_cfg(9, 0, 1);
      send_frame(9'h1A5, 9, 0, 1'b0, 1, 1'b1);
      wait_cyc(4);
      pop_chk("w9", 9'h1A5, 3'b000);
      set_cfg(5, 0, 0);
      send_frame(9'h015, 5, 0, 1'b0, 0, 1'b1);
      wait_cyc(bit_cyc);
      pop_chk("w5s0", 9'h015, 3'b000);

      // 5: fill a 4-deep FIFO with five chars
      set_cfg(8, 0, 1);
      ovr_base = ovr_cnt;
      for (int i = 1; i <= 5; i++) send_frame(9'(i), 8, 0, 1'b0, 1, 1'b1);
      wait_cyc(4);
      chk("t5_count", fifo_count, 4);
      chk("t5_overrun", ovr_cnt - ovr_base, 1);
      for (int i = 1; i <= 4; i++) pop_chk("t5_drain", 9'(i), 3'b000);
      chk("t5_empty", m_tvalid, 0);

      // 6a: short low glitch, no push
      uart_rx = 1'b0;
      wait_cyc(15);
      chk("t6a_busy", rx_busy, 1);
      uart_rx = 1'b1;
      wait_cyc(2 * bit_cyc);
      chk("t6a_idle", rx_busy, 0);
      chk("t6a_count", fifo_count, 0);

      // 6b: reset mid-DATA with a char already queued
      send_frame(9'h033, 8, 0, 1'b0, 1, 1'b1);
      wait_cyc(4);
      chk("t6b_pre", fifo_count, 1);
      uart_rx = 1'b0;
      wait_cyc(3 * bit_cyc);
      chk("t6b_busy", rx_busy, 1);
      areset = 1'b1;
      wait_cyc(1);
      chk_all_zero("t6b_rst");
      uart_rx = 1'b1;
      wait_cyc(2);
      areset = 1'b0;
      wait_cyc(12 * bit_cyc);
      chk("t6b_count", fifo_count, 0);
      chk("t6b_idle", rx_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
